// File: rtl/decode_stage_p_pkg.sv
// rtl/decode_stage_p_pkg.sv - opcode constants, ALU and result-source encodings for the decode stage
package decode_stage_p_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_t;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;

   // funct3 values shared by the R-type and I-ALU groups: add, slt, or, and
   function automatic logic funct3_alu_ok(input logic [2:0] f3);
      return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
   endfunction

   function automatic alu_ctrl_t alu_from_funct3(input logic [2:0] f3);
      case (f3)
         3'b010:  return ALU_SLT;
         3'b110:  return ALU_OR;
         3'b111:  return ALU_AND;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/regfile_p.sv
// rtl/regfile_p.sv - NREG x XLEN register file, two read ports, one write port with write-through
module regfile_p #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd
);

   logic [XLEN-1:0] regs [NREG];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (we && (wa != '0)) begin
         regs[wa] <= wd;
      end
   end

   // a write landing this cycle is forwarded so Decode never sees a stale value
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ra1 != '0) rd1 = (we && (wa == ra1)) ? wd : regs[ra1];
      if (ra2 != '0) rd2 = (we && (wa == ra2)) ? wd : regs[ra2];
   end

endmodule

// File: rtl/decode_stage_p.sv
// rtl/decode_stage_p.sv - instruction decode, register read, load-use stall and ID/EX pipeline register
module decode_stage_p #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW  = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     Instr_D,
   input  logic            Valid_D,
   input  logic            Flush_E,
   input  logic            RF_WE_W,
   input  logic [AW-1:0]   RF_WA_W,
   input  logic [XLEN-1:0] RF_WD_W,
   output logic [XLEN-1:0] RD1_E,
   output logic [XLEN-1:0] RD2_E,
   output logic [XLEN-1:0] Extend_E,
   output logic [AW-1:0]   RS1_E,
   output logic [AW-1:0]   RS2_E,
   output logic [AW-1:0]   RD_E,
   output logic [2:0]      Alu_ctrl_E,
   output logic            Alu_src_E,
   output logic            DM_Write_E,
   output logic            RF_WE_E,
   output logic            Branch_E,
   output logic [1:0]      Result_src_E,
   output logic            Valid_E,
   output logic            Illegal_E,
   output logic            Stall_D
);
   import decode_stage_p_pkg::*;

   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   logic [AW-1:0]   rs1, rs2, rd;
   logic [XLEN-1:0] rf_rd1, rf_rd2;
   logic [XLEN-1:0] imm_i, imm_s, imm_b;

   assign opcode = Instr_D[6:0];
   assign funct3 = Instr_D[14:12];
   assign funct7 = Instr_D[31:25];
   assign rd     = Instr_D[7 +: AW];
   assign rs1    = Instr_D[15 +: AW];
   assign rs2    = Instr_D[20 +: AW];
   assign imm_i  = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:20]};
   assign imm_s  = {{(XLEN-12){Instr_D[31]}}, Instr_D[31:25], Instr_D[11:7]};
   assign imm_b  = {{(XLEN-13){Instr_D[31]}}, Instr_D[31], Instr_D[7], Instr_D[30:25],
                    Instr_D[11:8], 1'b0};

   regfile_p #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_regfile (
      .clk (clk),
      .rst (rst),
      .ra1 (rs1),
      .ra2 (rs2),
      .rd1 (rf_rd1),
      .rd2 (rf_rd2),
      .we  (RF_WE_W),
      .wa  (RF_WA_W),
      .wd  (RF_WD_W)
   );

   alu_ctrl_t       d_alu;
   logic            d_src, d_dmw, d_we, d_br, d_ill, use_rs1, use_rs2;
   logic [1:0]      d_res;
   logic [XLEN-1:0] d_imm;

   always_comb begin
      d_alu   = ALU_ADD;
      d_src   = 1'b0;
      d_dmw   = 1'b0;
      d_we    = 1'b0;
      d_br    = 1'b0;
      d_ill   = 1'b0;
      d_res   = RES_ALU;
      d_imm   = '0;
      use_rs1 = 1'b1;
      use_rs2 = 1'b0;
      case (opcode)
         OP_R: begin
            d_we    = 1'b1;
            use_rs2 = 1'b1;
            d_alu   = alu_from_funct3(funct3);
            if (funct7 == 7'h20 && funct3 == 3'b000) d_alu = ALU_SUB;
            else if (funct7 != 7'h00 || !funct3_alu_ok(funct3)) d_ill = 1'b1;
         end
         OP_I: begin
            d_we  = 1'b1;
            d_src = 1'b1;
            d_alu = alu_from_funct3(funct3);
            d_imm = imm_i;
            d_ill = !funct3_alu_ok(funct3);
         end
         OP_LW: begin
            d_we  = 1'b1;
            d_src = 1'b1;
            d_res = RES_MEM;
            d_imm = imm_i;
            d_ill = (funct3 != 3'b010);
         end
         OP_SW: begin
            d_dmw   = 1'b1;
            d_src   = 1'b1;
            use_rs2 = 1'b1;
            d_imm   = imm_s;
            d_ill   = (funct3 != 3'b010);
         end
         OP_BEQ: begin
            d_alu   = ALU_SUB;
            d_br    = 1'b1;
            use_rs2 = 1'b1;
            d_imm   = imm_b;
            d_ill   = (funct3 != 3'b000);
         end
         default: d_ill = 1'b1;
      endcase
      // an unsupported encoding carries no side effects and reads no sources
      if (d_ill) begin
         d_alu   = ALU_ADD;
         d_src   = 1'b0;
         d_dmw   = 1'b0;
         d_we    = 1'b0;
         d_br    = 1'b0;
         d_res   = RES_ALU;
         d_imm   = '0;
         use_rs1 = 1'b0;
         use_rs2 = 1'b0;
      end
   end

   assign Stall_D = Valid_E && (Result_src_E == RES_MEM) && (RD_E != '0) && Valid_D &&
                    ((use_rs1 && RD_E == rs1) || (use_rs2 && RD_E == rs2));

   always_ff @(posedge clk) begin
      if (rst || Flush_E || Stall_D || !Valid_D) begin
         RD1_E        <= '0;
         RD2_E        <= '0;
         Extend_E     <= '0;
         RS1_E        <= '0;
         RS2_E        <= '0;
         RD_E         <= '0;
         Alu_ctrl_E   <= ALU_ADD;
         Alu_src_E    <= 1'b0;
         DM_Write_E   <= 1'b0;
         RF_WE_E      <= 1'b0;
         Branch_E     <= 1'b0;
         Result_src_E <= RES_ALU;
         Valid_E      <= 1'b0;
         Illegal_E    <= 1'b0;
      end else begin
         RD1_E        <= rf_rd1;
         RD2_E        <= rf_rd2;
         Extend_E     <= d_imm;
         RS1_E        <= rs1;
         RS2_E        <= rs2;
         RD_E         <= rd;
         Alu_ctrl_E   <= d_alu;
         Alu_src_E    <= d_src;
         DM_Write_E   <= d_dmw;
         RF_WE_E      <= d_we;
         Branch_E     <= d_br;
         Result_src_E <= d_res;
         Valid_E      <= 1'b1;
         Illegal_E    <= d_ill;
      end
   end

endmodule

// File: tb/tb_decode_stage_p.sv
// tb/tb_decode_stage_p.sv - self-checking bench for decode_stage_p with a behavioural reference model
module tb_decode_stage_p;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Instr_D;
   logic        Valid_D, Flush_E, RF_WE_W;
   logic [4:0]  RF_WA_W;
   logic [31:0] RF_WD_W;
   logic [31:0] RD1_E, RD2_E, Extend_E;
   logic [4:0]  RS1_E, RS2_E, RD_E;
   logic [2:0]  Alu_ctrl_E;
   logic        Alu_src_E, DM_Write_E, RF_WE_E, Branch_E;
   logic [1:0]  Result_src_E;
   logic        Valid_E, Illegal_E, Stall_D;

   always #5 clk = ~clk;

   decode_stage_p dut (
      .clk(clk), .rst(rst), .Instr_D(Instr_D), .Valid_D(Valid_D), .Flush_E(Flush_E),
      .RF_WE_W(RF_WE_W), .RF_WA_W(RF_WA_W), .RF_WD_W(RF_WD_W),
      .RD1_E(RD1_E), .RD2_E(RD2_E), .Extend_E(Extend_E),
      .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E), .Alu_ctrl_E(Alu_ctrl_E),
      .Alu_src_E(Alu_src_E), .DM_Write_E(DM_Write_E), .RF_WE_E(RF_WE_E), .Branch_E(Branch_E),
      .Result_src_E(Result_src_E), .Valid_E(Valid_E), .Illegal_E(Illegal_E), .Stall_D(Stall_D)
   );

   typedef struct packed {
      logic        valid, ill;
      logic [2:0]  alu;
      logic        src, dmw, we, br;
      logic [1:0]  res;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] rd1, rd2, ext;
   } e_t;

   e_t dut_e;
   assign dut_e = {Valid_E, Illegal_E, Alu_ctrl_E, Alu_src_E, DM_Write_E, RF_WE_E, Branch_E,
                   Result_src_E, RD_E, RS1_E, RS2_E, RD1_E, RD2_E, Extend_E};

   int          total = 0;
   int          bad = 0;
   logic [31:0] mrf [32];
   e_t          model_e;
   logic        exp_stall, seen_stall;

   localparam logic [31:0] ADD_6_1_2 = 32'h00208333;
   localparam logic [31:0] LW_1_0_2  = 32'h00012083;

   function automatic logic [2:0] alu_of(input logic [2:0] f3);
      case (f3)
         3'd2:    return 3'b101;
         3'd6:    return 3'b011;
         3'd7:    return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic e_t model_decode(input logic [31:0] ins, input logic [31:0] a,
                                       input logic [31:0] b);
      e_t          e = '0;
      logic [6:0]  op = ins[6:0];
      logic [2:0]  f3 = ins[14:12];
      logic [6:0]  f7 = ins[31:25];
      logic [11:0] ii = ins[31:20];
      logic [11:0] si = {ins[31:25], ins[11:7]};
      logic [12:0] bi = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      e.valid = 1'b1;
      e.rd = ins[11:7];
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.rd1 = a;
      e.rd2 = b;
      if (op == 7'h33 && f7 == 7'h00 && f3 inside {3'd0, 3'd2, 3'd6, 3'd7}) begin
         e.we = 1'b1; e.alu = alu_of(f3);
      end else if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) begin
         e.we = 1'b1; e.alu = 3'b001;
      end else if (op == 7'h13 && f3 inside {3'd0, 3'd2, 3'd6, 3'd7}) begin
         e.we = 1'b1; e.src = 1'b1; e.alu = alu_of(f3); e.ext = 32'($signed(ii));
      end else if (op == 7'h03 && f3 == 3'd2) begin
         e.we = 1'b1; e.src = 1'b1; e.res = 2'b01; e.ext = 32'($signed(ii));
      end else if (op == 7'h23 && f3 == 3'd2) begin
         e.dmw = 1'b1; e.src = 1'b1; e.ext = 32'($signed(si));
      end else if (op == 7'h63 && f3 == 3'd0) begin
         e.br = 1'b1; e.alu = 3'b001; e.ext = 32'($signed(bi));
      end else begin
         e.ill = 1'b1;
      end
      return e;
   endfunction

   function automatic logic model_hazard(input logic [31:0] ins, input logic v);
      e_t   d = model_decode(ins, 32'd0, 32'd0);
      logic r2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
      if (!(model_e.valid && model_e.res == 2'b01 && model_e.rd != 5'd0 && v && !d.ill))
         return 1'b0;
      return (model_e.rd == ins[19:15]) || (r2 && model_e.rd == ins[24:20]);
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] r, input logic we,
                                              input logic [4:0] wa, input logic [31:0] wd);
      if (r == 5'd0) return 32'd0;
      if (we && wa == r) return wd;
      return mrf[r];
   endfunction

   // drives one cycle, advances the reference model, leaves the bench 1ns past the edge
   task automatic step(input logic [31:0] ins, input logic v, input logic fl, input logic r,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
      e_t nxt;
      Instr_D = ins; Valid_D = v; Flush_E = fl; rst = r;
      RF_WE_W = we; RF_WA_W = wa; RF_WD_W = wd;
      #1;
      exp_stall  = model_hazard(ins, v);
      seen_stall = Stall_D;
      if (r || fl || exp_stall || !v) nxt = '0;
      else nxt = model_decode(ins, model_read(ins[19:15], we, wa, wd),
                              model_read(ins[24:20], we, wa, wd));
      @(posedge clk);
      #1;
      if (r) begin
         for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      end else if (we && wa != 5'd0) begin
         mrf[wa] = wd;
      end
      model_e = nxt;
   endtask

   task automatic test_reset();
      step(ADD_6_1_2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h55);
      total++; if (dut_e !== '0) begin bad++; $display("FAIL reset_e_outputs got=%h want=0", dut_e); end
      total++; if (Stall_D !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", Stall_D); end
      step(ADD_6_1_2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      total++; if (RD1_E !== 32'd0) begin bad++; $display("FAIL reset_regs_cleared got=%h want=0", RD1_E); end
   endtask

   task automatic test_rtype();
      step(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5);
      step(32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2, 32'd3);
      step(ADD_6_1_2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      total++;
      if ({RD1_E, RD2_E, Alu_ctrl_E, RD_E, RF_WE_E, Valid_E} !== {32'd5, 32'd3, 3'b000, 5'd6, 1'b1, 1'b1}) begin
         bad++;
         $display("FAIL add_fields got rd1=%0d rd2=%0d alu=%b rd=%0d we=%b v=%b want 5 3 000 6 1 1",
                  RD1_E, RD2_E, Alu_ctrl_E, RD_E, RF_WE_E, Valid_E);
      end
      total++; if (dut_e !== model_e) begin bad++; $display("FAIL add_model got=%h want=%h", dut_e, model_e); end
   endtask

   task automatic test_alu_imm();
      step(32'h40208333, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      total++; if (Alu_ctrl_E !== 3'b001) begin bad++; $display("FAIL sub_alu got=%b want=001", Alu_ctrl_E); end
      step(32'h00918113, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      total++;
      if ({Extend_E, Alu_src_E, RD_E} !== {32'd9, 1'b1, 5'd2}) begin
         bad++; $display("FAIL addi_fields got ext=%h src=%b rd=%0d want 9 1 2", Extend_E, Alu_src_E, RD_E);
      end
      step(32'hFE112E23, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      total++;
      if ({Extend_E, DM_Write_E, RF_WE_E, Alu_src_E} !== {32'hFFFFFFFC, 1'b1, 1'b0, 1'b1}) begin
         bad++; $display("FAIL sw_fields got ext=%h dmw=%b we=%b src=%b want fffffffc 1 0 1",
                         Extend_E, DM_Write_E, RF_WE_E, Alu_src_E);
      end
      step(32'hFE208CE3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      total++;
      if ({Extend_E, Branch_E, Alu_ctrl_E, Alu_src_E} !== {32'hFFFFFFF8, 1'b1, 3'b001, 1'b0}) begin
         bad++; $display("FAIL beq_fields got ext=%h br=%b alu=%b src=%b want fffffff8 1 001 0",
                         Extend_E, Branch_E, Alu_ctrl_E, Alu_src_E);
      end
   endtask

   task automatic test_load_use();
      step(LW_1_0_2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      total++;
      if ({Result_src_E, Valid_E, RD_E} !== {2'b01, 1'b1, 5'd1}) begin
         bad++; $display("FAIL lw_fields got res=%b v=%b rd=%0d want 01 1 1", Result_src_E, Valid_E, RD_E);
      end
      step(ADD_6_1_2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      total++; if (seen_stall !== 1'b1) begin bad++; $display("FAIL load_use_stall got=%b want=1", seen_stall); end
      total++; if (Valid_E !== 1'b0) begin bad++; $display("FAIL load_use_bubble got=%b want=0", Valid_E); end
      step(ADD_6_1_2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      total++; if (seen_stall !== 1'b0) begin bad++; $display("FAIL stall_one_cycle got=%b want=0", seen_stall); end
      total++;
      if ({Valid_E, RF_WE_E, RD_E} !== {1'b1, 1'b1, 5'd6}) begin
         bad++; $display("FAIL add_after_stall got v=%b we=%b rd=%0d want 1 1 6", Valid_E, RF_WE_E, RD_E);
      end
   endtask

   task automatic test_bypass();
      step(ADD_6_1_2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 32'hDEAD);
      total++; if (RD1_E !== 32'hDEAD) begin bad++; $display("FAIL bypass_x1 got=%h want=dead", RD1_E); end
      step(32'h00000333, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1234);
      total++;
      if ({RD1_E, RD2_E} !== 64'd0) begin bad++; $display("FAIL x0_bypass got=%h/%h want=0", RD1_E, RD2_E); end
      step(32'h00000333, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      total++; if (RD1_E !== 32'd0) begin bad++; $display("FAIL x0_write_ignored got=%h want=0", RD1_E); end
   endtask

   task automatic test_flush_illegal();
      step(ADD_6_1_2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      total++;
      if ({Valid_E, RF_WE_E} !== 2'b00) begin bad++; $display("FAIL flush_bubble got v=%b we=%b want 0 0", Valid_E, RF_WE_E); end
      step(32'h0000007F, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      total++;
      if ({Illegal_E, Valid_E, RF_WE_E, DM_Write_E, Branch_E} !== 5'b11000) begin
         bad++; $display("FAIL illegal_op got ill=%b v=%b we=%b dmw=%b br=%b want 1 1 0 0 0",
                         Illegal_E, Valid_E, RF_WE_E, DM_Write_E, Branch_E);
      end
      step(ADD_6_1_2, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      total++; if (Valid_E !== 1'b0) begin bad++; $display("FAIL invalid_d_bubble got=%b want=0", Valid_E); end
   endtask

   task automatic test_reset_mid_stall();
      step(LW_1_0_2, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      step(ADD_6_1_2, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
      total++; if (seen_stall !== 1'b1) begin bad++; $display("FAIL pre_reset_stall got=%b want=1", seen_stall); end
      total++; if (Stall_D !== 1'b0) begin bad++; $display("FAIL reset_clears_stall got=%b want=0", Stall_D); end
      total++; if (dut_e !== '0) begin bad++; $display("FAIL reset_mid_stall_e got=%h want=0", dut_e); end
   endtask

   task automatic test_random();
      logic [31:0] ins = 32'd0;
      logic        v = 1'b0, held = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!held) begin
            logic [4:0] rd = 5'($urandom_range(0, 5));
            logic [4:0] r1 = 5'($urandom_range(0, 3));
            logic [4:0] r2 = 5'($urandom_range(0, 3));
            logic [2:0] f3 = 3'($urandom_range(0, 7));
            logic [6:0] f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            case ($urandom_range(0, 6))
               0: ins = {f7, r2, r1, f3, rd, 7'h33};
               1: ins = {7'($urandom), r2, r1, f3, rd, 7'h13};
               2, 5: ins = {7'($urandom), 5'($urandom), r1, 3'b010, rd, 7'h03};
               3: ins = {7'($urandom), r2, r1, 3'b010, 5'($urandom), 7'h23};
               4: ins = {7'($urandom), r2, r1, 3'b000, 5'($urandom), 7'h63};
               default: ins = $urandom;
            endcase
            v = ($urandom_range(0, 9) != 0);
         end
         step(ins, v, ($urandom_range(0, 9) == 0), 1'b0, 1'($urandom),
              5'($urandom_range(0, 3)), $urandom);
         held = exp_stall;
         total++;
         if (seen_stall !== exp_stall) begin
            bad++; $display("FAIL rand_stall n=%0d got=%b want=%b", n, seen_stall, exp_stall);
         end
         total++;
         if (model_e.valid ? (dut_e !== model_e)
                           : ({dut_e.valid, dut_e.we, dut_e.dmw, dut_e.br, dut_e.ill} !== 5'b0)) begin
            bad++; $display("FAIL rand_e n=%0d got=%h want=%h", n, dut_e, model_e);
         end
      end
   endtask

   initial begin
      rst = 1'b1; Instr_D = '0; Valid_D = 1'b0; Flush_E = 1'b0;
      RF_WE_W = 1'b0; RF_WA_W = '0; RF_WD_W = '0;
      model_e = '0;
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      @(posedge clk);
      #1;
      test_reset();
      test_rtype();
      test_alu_imm();
      test_load_use();
      test_bypass();
      test_flush_illegal();
      test_reset_mid_stall();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/decode_stage_p.md
DECODE_STAGE_P -- requirements
Module: decode_stage_p

Interface
REQ-001 Parameter XLEN, default 32, datapath and register width.
REQ-002 Parameter NREG, default 32, register count; AW = clog2(NREG) address bits.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 Instr_D  in  32  instruction in Decode.
REQ-006 Valid_D  in  1  Instr_D is a real instruction.
REQ-007 Flush_E  in  1  next ID/EX contents become a bubble.
REQ-008 RF_WE_W / RF_WA_W / RF_WD_W  in  1/AW/XLEN  write-back enable, address, data.
REQ-009 RD1_E, RD2_E, Extend_E  out  XLEN  registered operands and sign-extended immediate.
REQ-010 RS1_E, RS2_E, RD_E  out  AW  registered source and destination addresses.
REQ-011 Alu_ctrl_E  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-012 Alu_src_E, DM_Write_E, RF_WE_E, Branch_E  out  1  registered controls.
REQ-013 Result_src_E  out  2  00 ALU, 01 memory.
REQ-014 Valid_E, Illegal_E  out  1  E-stage valid; unsupported opcode flag.
REQ-015 Stall_D  out  1  combinational load-use stall request to Fetch/Decode.

Function
REQ-016 Decode SHALL support R-type (0110011: add, sub, slt, or, and), I-ALU (0010011: addi, slti, ori, andi), lw (0000011/010), sw (0100011/010), beq (1100011/000).
REQ-017 R-type: Alu_src 0, RF_WE 1; sub when funct7[5]=1 and funct3=000.
REQ-018 I-ALU: Alu_src 1, RF_WE 1, immediate instr[31:20] sign-extended to XLEN.
REQ-019 lw: add, Alu_src 1, RF_WE 1, Result_src 01; sw: add, Alu_src 1, DM_Write 1, imm {[31:25],[11:7]}.
REQ-020 beq: sub, Alu_src 0, Branch 1, imm {[31],[7],[30:25],[11:8],0} sign-extended.
REQ-021 Any other encoding SHALL set Illegal_E=1 with all write/branch controls 0.
REQ-022 Register file: NREG x XLEN; register 0 always reads 0; writes to address 0 ignored.
REQ-023 Write occurs at rising edge when RF_WE_W=1; same-cycle read of RF_WA_W (nonzero) SHALL return RF_WD_W (write-through bypass).
REQ-024 All E outputs SHALL be registered: Decode values appear one cycle after sampling.
REQ-025 Stall_D=1 when Valid_E, Result_src_E=01, RD_E!=0 and RD_E equals a source register actually used by Instr_D (rs2 only for R-type, sw, beq).
REQ-026 Stall or Flush_E SHALL load a bubble: Valid_E=0, RF_WE_E, DM_Write_E, Branch_E, Illegal_E=0.
REQ-027 Flush_E takes priority over stall; Valid_D=0 also yields a bubble.
REQ-028 Upstream holds Instr_D while Stall_D=1; the stall lasts exactly one cycle.

Reset
REQ-029 While rst=1 at a rising edge: all E outputs 0, Valid_E 0, all registers cleared to 0.
REQ-030 Reset asserted mid-stall SHALL clear the stall on the next cycle (Stall_D derives only from reset E state).

Structure
REQ-031 Shared package holds opcode constants, Alu_ctrl and Result_src encodings.
REQ-032 One sub-module: regfile_p (NREG x XLEN, two read ports, one write port, write-through bypass).

Verification
REQ-033 Write x1=5, x2=3; then 0x00208333 (add x6,x1,x2) -> next cycle RD1_E=5, RD2_E=3, Alu_ctrl_E=000, RD_E=6, RF_WE_E=1, Valid_E=1.
REQ-034 0x40208333 -> Alu_ctrl_E=001; 0x00918113 (addi x2,x3,9) -> Extend_E=9, Alu_src_E=1, RD_E=2.
REQ-035 0x00012083 (lw x1,0(x2)) then 0x00208333 -> Stall_D=1 one cycle, one bubble (Valid_E=0), then add with Valid_E=1.
REQ-036 RF_WE_W=1, RF_WA_W=1, RF_WD_W=0xDEAD same cycle as add reading x1 -> RD1_E=0xDEAD; write to x0 -> x0 reads 0.
REQ-037 Flush_E=1 with valid add -> Valid_E=0, RF_WE_E=0; opcode 0x7F -> Illegal_E=1; rst=1 -> all outputs 0 next edge.
